// File: rtl/mult16_arbiter_pkg.sv
// Shared types and helpers for the round-robin multiplier arbiter.
// Holds the FSM state encoding, operand/product widths and the grant picker.
package mult_arb_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // First set bit of valid at or above ptr, wrapping at num_req (up to 8 requesters).
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         num_req);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(ptr) + i) % num_req;
            if (!found && (i < num_req) && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult16_arbiter_if.sv
// Requester-side bundle of the multiplier arbiter: operand request and product response.
// The master modport belongs to the requesters, the slave modport to the arbiter.
interface mult16_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import mult_arb_pkg::*;

    logic [NUM_REQ-1:0]      req_valid;
    logic [OP_W*NUM_REQ-1:0] req_a;
    logic [OP_W*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [NUM_REQ-1:0]      rsp_ack;
    logic [PROD_W-1:0]       rsp_c;
    logic                    busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ack,
        input  req_ready, rsp_valid, rsp_c, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ack,
        output req_ready, rsp_valid, rsp_c, busy
    );

endinterface

// File: rtl/mult16_arbiter_array16.sv
// Unsigned 16x16 combinational array multiplier; its carry path is multi-cycle,
// so the arbiter holds the operands stable for several clocks before sampling c.
module array16
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] c
);

    assign c = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mult16_arbiter.sv
// Round-robin scheduler sharing one array16 multiplier among NUM_REQ requesters,
// holding operands SETTLE_CYCLES clocks before capturing and returning the product.
module mult16_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk_dut,
    input  logic            rst_n,
    mult16_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [PROD_W-1:0]  rsp_c_q, rsp_c_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0] req_ready;
    logic [IDX_W-1:0]   pick;
    logic [PROD_W-1:0]  prod;

    array16 u_array16 (
        .a (a_q),
        .b (b_q),
        .c (prod)
    );

    assign pick = IDX_W'(rr_pick(8'(bus.req_valid), 3'(rr_ptr_q), NUM_REQ));

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_c_d     = rsp_c_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    req_ready[pick] = 1'b1;
                    a_d     = bus.req_a[int'(pick)*OP_W +: OP_W];
                    b_d     = bus.req_b[int'(pick)*OP_W +: OP_W];
                    gnt_d   = pick;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_c_d     = prod;
                    rsp_valid_d = NUM_REQ'(1) << gnt_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Only the granted requester's ack retires the response.
                if (bus.rsp_ack[gnt_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_dut) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_c_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_c_q     <= rsp_c_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
